cache_model_dm: RTL and testbench

- Parametrised, direct-mapped, write-through, write-allocate cache model with an internal backing memory.
- Successor to the fixed 8-bit-address / 32-bit-data cache model. Adds configurable geometry, a valid/ready request handshake, a modelled read-miss penalty, and hit/miss statistics with report snapshots.
- Used in simulation testbenches to characterise access streams. It is not a synthesis target.

---
 rtl/cache_model_dm_if.sv | 30 +++
 rtl/cache_model_dm.sv | 182 ++++++++++++++++++
 tb/tb_cache_model_dm.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/cache_model_dm_if.sv
// Request/response and statistics bundle for cache_model_dm.
// The master drives requests and report; the slave (cache) returns responses and snapshots.
interface cache_model_dm_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
);
  logic              req_valid;
  logic              req_ready;
  logic              write_en;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] write_data;
  logic              resp_valid;
  logic              hit;
  logic [DATA_W-1:0] read_data;
  logic              report;
  logic              report_valid;
  logic [CNT_W-1:0]  hit_stat;
  logic [CNT_W-1:0]  miss_stat;

  modport master (
    output req_valid, write_en, address, write_data, report,
    input  req_ready, resp_valid, hit, read_data, report_valid, hit_stat, miss_stat
  );

  modport slave (
    input  req_valid, write_en, address, write_data, report,
    output req_ready, resp_valid, hit, read_data, report_valid, hit_stat, miss_stat
  );
endinterface

// File: rtl/cache_model_dm.sv
// Direct-mapped write-through/write-allocate cache model with backing memory and hit/miss stats.
// Hits and writes respond 1 cycle after acceptance, read misses 1+MISS_LAT; one access in flight, req_ready low while busy.
module cache_model_dm #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 32,
  parameter int INDEX_W  = 4,
  parameter int MISS_LAT = 4,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  cache_model_dm_if.slave  bus
);
  localparam int TAG_W = ADDR_W - INDEX_W;
  localparam int LINES = 1 << INDEX_W;
  localparam int DEPTH = 1 << ADDR_W;
  localparam int LAT_W = (MISS_LAT > 1) ? $clog2(MISS_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {IDLE, LOOKUP, MISS_WAIT} state_t;

  state_t            state_q, state_d;
  logic [LAT_W-1:0]  cnt_q, cnt_d;
  logic              req_we_q;
  logic [ADDR_W-1:0] req_addr_q;
  logic [DATA_W-1:0] req_wdata_q;
  logic              rdy_q;

  logic              line_vld_q [LINES];
  logic [TAG_W-1:0]  line_tag_q [LINES];
  logic [DATA_W-1:0] line_dat_q [LINES];
  logic [DATA_W-1:0] mem_q      [DEPTH];

  logic              resp_q, resp_d;
  logic              hit_q, hit_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [CNT_W-1:0]  hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;
  logic [CNT_W-1:0]  hit_stat_q, hit_stat_d, miss_stat_q, miss_stat_d;
  logic              rpt_vld_q;

  logic [INDEX_W-1:0] idx;
  logic [TAG_W-1:0]   tag;
  logic               tag_match;
  logic               accept;
  logic               line_wr;
  logic [DATA_W-1:0]  line_wdat;
  logic               mem_wr;

  assign idx       = req_addr_q[INDEX_W-1:0];
  assign tag       = req_addr_q[ADDR_W-1:INDEX_W];
  assign tag_match = line_vld_q[idx] && (line_tag_q[idx] == tag);
  assign accept    = bus.req_valid && rdy_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    resp_d    = 1'b0;
    hit_d     = 1'b0;
    rdata_d   = rdata_q;
    line_wr   = 1'b0;
    line_wdat = '0;
    mem_wr    = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) state_d = LOOKUP;
      end
      LOOKUP: begin
        if (req_we_q) begin
          line_wr   = 1'b1;
          line_wdat = req_wdata_q;
          mem_wr    = 1'b1;
          resp_d    = 1'b1;
          hit_d     = tag_match;
          state_d   = IDLE;
        end else if (tag_match) begin
          resp_d  = 1'b1;
          hit_d   = 1'b1;
          rdata_d = line_dat_q[idx];
          state_d = IDLE;
        end else begin
          cnt_d   = LAT_W'(MISS_LAT - 1);
          state_d = MISS_WAIT;
        end
      end
      MISS_WAIT: begin
        if (cnt_q == '0) begin
          line_wr   = 1'b1;
          line_wdat = mem_q[req_addr_q];
          resp_d    = 1'b1;
          rdata_d   = mem_q[req_addr_q];
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A report clears the counters first, so an access completing on the same edge lands in the fresh count.
  always_comb begin
    hit_cnt_d   = hit_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    hit_stat_d  = hit_stat_q;
    miss_stat_d = miss_stat_q;
    if (bus.report) begin
      hit_stat_d  = hit_cnt_q;
      miss_stat_d = miss_cnt_q;
      hit_cnt_d   = '0;
      miss_cnt_d  = '0;
    end
    if (resp_d) begin
      if (hit_d) begin
        if (hit_cnt_d != CNT_MAX) hit_cnt_d = hit_cnt_d + 1'b1;
      end else begin
        if (miss_cnt_d != CNT_MAX) miss_cnt_d = miss_cnt_d + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      req_we_q    <= 1'b0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      rdy_q       <= 1'b0;
      resp_q      <= 1'b0;
      hit_q       <= 1'b0;
      rdata_q     <= '0;
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
      hit_stat_q  <= '0;
      miss_stat_q <= '0;
      rpt_vld_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rdy_q       <= (state_d == IDLE);
      resp_q      <= resp_d;
      hit_q       <= hit_d;
      rdata_q     <= rdata_d;
      hit_cnt_q   <= hit_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
      hit_stat_q  <= hit_stat_d;
      miss_stat_q <= miss_stat_d;
      rpt_vld_q   <= bus.report;
      if (accept) begin
        req_we_q    <= bus.write_en;
        req_addr_q  <= bus.address;
        req_wdata_q <= bus.write_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < LINES; i++) begin
        line_vld_q[i] <= 1'b0;
        line_tag_q[i] <= '0;
        line_dat_q[i] <= '0;
      end
      for (int j = 0; j < DEPTH; j++) mem_q[j] <= '0;
    end else begin
      if (line_wr) begin
        line_vld_q[idx] <= 1'b1;
        line_tag_q[idx] <= tag;
        line_dat_q[idx] <= line_wdat;
      end
      if (mem_wr) mem_q[req_addr_q] <= req_wdata_q;
    end
  end

  assign bus.req_ready    = rdy_q;
  assign bus.resp_valid   = resp_q;
  assign bus.hit          = hit_q;
  assign bus.read_data    = rdata_q;
  assign bus.report_valid = rpt_vld_q;
  assign bus.hit_stat     = hit_stat_q;
  assign bus.miss_stat    = miss_stat_q;
endmodule

// File: tb/tb_cache_model_dm.sv
// Directed bench for cache_model_dm: expected responses queue at acceptance and are checked at resp_valid.
module tb_cache_model_dm;
  localparam int AW = 8;
  localparam int DW = 32;
  localparam int IW = 4;
  localparam int ML = 4;
  localparam int CW = 2;

  typedef struct {
    logic          hit;
    logic          is_rd;
    logic [DW-1:0] data;
    int            lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];

  cache_model_dm_if #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) bus ();

  cache_model_dm #(
    .ADDR_W(AW), .DATA_W(DW), .INDEX_W(IW), .MISS_LAT(ML), .CNT_W(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic eh, input logic [DW-1:0] ed, input int el);
    int   w;
    exp_t e;
    w = 0;
    bus.req_valid  = 1'b1;
    bus.write_en   = we;
    bus.address    = a;
    bus.write_data = d;
    while (bus.req_ready !== 1'b1 && w < 20) begin
      tick();
      w++;
    end
    chk("req_ready_wait", 64'(bus.req_ready), 64'(1));
    e.hit = eh; e.is_rd = !we; e.data = ed; e.lat = el;
    sb.push_back(e);
    tick();
    bus.req_valid = 1'b0;
    chk("req_ready_drop", 64'(bus.req_ready), 64'(0));
  endtask

  task automatic wait_resp();
    int   lat;
    exp_t e;
    lat = 0;
    do begin
      tick();
      lat++;
    end while (bus.resp_valid !== 1'b1 && lat < 20);
    chk("resp_seen", 64'(bus.resp_valid), 64'(1));
    chk("sb_size", 64'(sb.size()), 64'(1));
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("latency", 64'(lat), 64'(e.lat));
      chk("hit", 64'(bus.hit), 64'(e.hit));
      if (e.is_rd) chk("read_data", 64'(bus.read_data), 64'(e.data));
      chk("ready_back", 64'(bus.req_ready), 64'(1));
    end
  endtask

  task automatic access(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic eh, input logic [DW-1:0] ed, input int el);
    issue(we, a, d, eh, ed, el);
    wait_resp();
  endtask

  task automatic do_report(input logic [CW-1:0] eh, input logic [CW-1:0] em);
    bus.report = 1'b1;
    tick();
    bus.report = 1'b0;
    chk("report_valid", 64'(bus.report_valid), 64'(1));
    chk("hit_stat", 64'(bus.hit_stat), 64'(eh));
    chk("miss_stat", 64'(bus.miss_stat), 64'(em));
    tick();
    chk("report_valid_drop", 64'(bus.report_valid), 64'(0));
  endtask

  initial begin
    bus.req_valid  = 1'b0;
    bus.write_en   = 1'b0;
    bus.address    = '0;
    bus.write_data = '0;
    bus.report     = 1'b0;
    #1 rst = 1'b0;
    repeat (5) tick();
    chk("rst_req_ready", 64'(bus.req_ready), 64'(0));
    chk("rst_resp_valid", 64'(bus.resp_valid), 64'(0));
    chk("rst_hit", 64'(bus.hit), 64'(0));
    chk("rst_report_valid", 64'(bus.report_valid), 64'(0));
    chk("rst_read_data", 64'(bus.read_data), 64'(0));
    chk("rst_stats", 64'({bus.hit_stat, bus.miss_stat}), 64'(0));
    rst = 1'b1;
    tick();
    chk("ready_after_rst", 64'(bus.req_ready), 64'(1));
    do_report(0, 0);

    // Write allocate, then hit; conflict on index 2 forces refills from backing memory.
    access(1'b1, 8'h02, 32'h00ABCDEF, 1'b0, 32'h0, 1);
    access(1'b0, 8'h02, 32'h0, 1'b1, 32'h00ABCDEF, 1);
    access(1'b0, 8'h12, 32'h0, 1'b0, 32'h0, 1 + ML);
    access(1'b0, 8'h02, 32'h0, 1'b0, 32'h00ABCDEF, 1 + ML);
    do_report(1, 3);

    access(1'b0, 8'h02, 32'h0, 1'b1, 32'h00ABCDEF, 1);
    do_report(1, 0);

    // Counter saturation at 2 bits.
    repeat (5) access(1'b0, 8'h02, 32'h0, 1'b1, 32'h00ABCDEF, 1);
    do_report(3, 0);

    // Report on the same edge as a hit completion.
    repeat (2) access(1'b0, 8'h02, 32'h0, 1'b1, 32'h00ABCDEF, 1);
    issue(1'b0, 8'h02, 32'h0, 1'b1, 32'h00ABCDEF, 1);
    bus.report = 1'b1;
    wait_resp();
    bus.report = 1'b0;
    chk("coll_report_valid", 64'(bus.report_valid), 64'(1));
    chk("coll_hit_stat", 64'(bus.hit_stat), 64'(2));
    chk("coll_miss_stat", 64'(bus.miss_stat), 64'(0));
    tick();
    chk("coll_resp_drop", 64'(bus.resp_valid), 64'(0));
    // Report held two cycles gives two snapshots.
    bus.report = 1'b1;
    tick();
    chk("hold1_valid", 64'(bus.report_valid), 64'(1));
    chk("hold1_hit_stat", 64'(bus.hit_stat), 64'(1));
    tick();
    bus.report = 1'b0;
    chk("hold2_valid", 64'(bus.report_valid), 64'(1));
    chk("hold2_hit_stat", 64'(bus.hit_stat), 64'(0));
    tick();
    chk("hold_valid_drop", 64'(bus.report_valid), 64'(0));

    // Write hit on a resident line, then read it back.
    access(1'b0, 8'h12, 32'h0, 1'b0, 32'h0, 1 + ML);
    access(1'b1, 8'h12, 32'h00000055, 1'b1, 32'h0, 1);
    access(1'b0, 8'h12, 32'h0, 1'b1, 32'h00000055, 1);

    // Reset two cycles into MISS_WAIT of a read miss on 0x02.
    issue(1'b0, 8'h02, 32'h0, 1'b0, 32'h00ABCDEF, 1 + ML);
    repeat (3) tick();
    rst = 1'b0;
    sb.delete();
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("midrst_no_resp", 64'(bus.resp_valid), 64'(0));
    end
    chk("midrst_ready", 64'(bus.req_ready), 64'(0));
    rst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("post_rst_no_resp", 64'(bus.resp_valid), 64'(0));
    end
    access(1'b0, 8'h02, 32'h0, 1'b0, 32'h0, 1 + ML);
    do_report(0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
